descriptor_memory_dp: RTL



---
 rtl/descriptor_memory_dp.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/descriptor_memory_dp.sv
// rtl/descriptor_memory_dp.sv - dual-port descriptor memory with post-reset clear engine
//
// Two independent Avalon-MM slave ports (s1: CPU, s2: DMA descriptor engine)
// share one word array. Byte-enable writes, pipelined read-first reads with
// readdatavalid, s1-wins write-collision stall on s2, and a CLEAR state that
// zeroes the array one word per enabled cycle after reset.
//
// Ports:
//   clk, reset_n        single clock, asynchronous active-low reset
//   clken               global clock enable; low freezes all state
//   sN_address          word address
//   sN_chipselect       port select
//   sN_write / sN_read  requests (both high is treated as a write)
//   sN_byteenable       write byte lanes
//   sN_writedata        write data
//   sN_readdata         read data, qualified by sN_readdatavalid
//   sN_waitrequest      request not accepted this cycle
//   init_done           high once the clear sequence has finished
module descriptor_memory_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 1,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_write,
  input  logic                    s1_read,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_write,
  input  logic                    s2_read,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    init_done
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic run;
  logic collision;
  logic s1_wr, s1_rd, s1_in_range;
  logic s2_wr, s2_rd, s2_in_range;
  logic [DATA_WIDTH-1:0] s1_cap, s2_cap;

  // Read pipelines: stage 0 captures the array (old data at the accept edge),
  // the last stage drives the port outputs.
  logic [DATA_WIDTH-1:0] p1_data [READ_LATENCY+1];
  logic [DATA_WIDTH-1:0] p2_data [READ_LATENCY+1];
  logic [READ_LATENCY:0] p1_vld;
  logic [READ_LATENCY:0] p2_vld;

  assign run = (state == RUN);

  // Read+write together counts as a write, so collision looks at write only.
  assign collision = s1_chipselect && s1_write && s2_chipselect && s2_write &&
                     (s1_address == s2_address);

  assign s1_waitrequest = !run || !clken;
  assign s2_waitrequest = !run || !clken || collision;

  assign s1_wr = s1_chipselect && s1_write && !s1_waitrequest;
  assign s1_rd = s1_chipselect && s1_read && !s1_write && !s1_waitrequest;
  assign s2_wr = s2_chipselect && s2_write && !s2_waitrequest;
  assign s2_rd = s2_chipselect && s2_read && !s2_write && !s2_waitrequest;

  assign s1_in_range = ({1'b0, s1_address} < DEPTH_L);
  assign s2_in_range = ({1'b0, s2_address} < DEPTH_L);

  always_comb begin
    s1_cap = '0;
    s2_cap = '0;
    if (s1_in_range) s1_cap = mem[s1_address];
    if (s2_in_range) s2_cap = mem[s2_address];
  end

  // Array: not reset. s1 is written last so it would win, although a
  // same-address s2 write is already stalled by the collision logic.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (!run) begin
        mem[clr_addr] <= '0;
      end else begin
        if (s2_wr && s2_in_range) begin
          for (int b = 0; b < BE_W; b++)
            if (s2_byteenable[b]) mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
        end
        if (s1_wr && s1_in_range) begin
          for (int b = 0; b < BE_W; b++)
            if (s1_byteenable[b]) mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
        end
      end
    end
  end

  // Clear engine FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= (INIT_CLEAR != 0) ? CLEAR : RUN;
      clr_addr  <= '0;
      init_done <= (INIT_CLEAR == 0);
    end else if (clken) begin
      case (state)
        CLEAR: begin
          if (clr_addr == LAST) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Data stages only advance behind a valid read, so readdata holds the
  // last returned word between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= READ_LATENCY; i++) begin
        p1_data[i] <= '0;
        p2_data[i] <= '0;
      end
      p1_vld <= '0;
      p2_vld <= '0;
    end else if (clken) begin
      p1_vld <= {p1_vld[READ_LATENCY-1:0], s1_rd};
      p2_vld <= {p2_vld[READ_LATENCY-1:0], s2_rd};
      if (s1_rd) p1_data[0] <= s1_cap;
      if (s2_rd) p2_data[0] <= s2_cap;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        if (p1_vld[i-1]) p1_data[i] <= p1_data[i-1];
        if (p2_vld[i-1]) p2_data[i] <= p2_data[i-1];
      end
    end
  end

  assign s1_readdata      = p1_data[READ_LATENCY];
  assign s1_readdatavalid = p1_vld[READ_LATENCY];
  assign s2_readdata      = p2_data[READ_LATENCY];
  assign s2_readdatavalid = p2_vld[READ_LATENCY];

endmodule
